aximm_ll_multi_tier2_slave_name: RTL
====================================

Name: aximm_ll_multi_tier2_slave_name

Overview:
Slave-end logic-link name/packing block for the 4-channel tier-2 AXI-MM multi-channel link. It is the counterpart of the master-side mapping.
- RX path: splits each 316-bit rxfifo word into four 79-bit channel words, buffering each channel independently with valid/ready handshakes.
- TX path: aligns four independently arriving channel words and emits one 316-bit txfifo word.
- Sits between the slave AXI channel packers and the logic-link FIFOs.

Parameters:
CH_W, 79, width of one channel word
NUM_CH, 4, number of channels
LL_W, 316, logic-link word width (NUM_CH*CH_W)
RX_DEPTH, 2, entries per channel RX FIFO (power of two, >=2)

Ports:
clk_wr  in  1  block clock
rst_wr  in  1  synchronous, active-high reset
rxfifo_rx_data  in  316  incoming link word; channel k occupies [k*79 +: 79]
rxfifo_rx_vld  in  1  link word valid
rxfifo_rx_rdy  out  1  link word accepted when vld&rdy
chN_rx_data (N=0..3)  out  79  channel N head-of-FIFO data
chN_rx_vld (N=0..3)  out  1  channel N data valid
chN_rx_rdy (N=0..3)  in  1  channel N consumer ready
chN_tx_data (N=0..3)  in  79  channel N outgoing word
chN_tx_vld (N=0..3)  in  1  channel N word valid
chN_tx_rdy (N=0..3)  out  1  channel N word accepted when vld&rdy
txfifo_tx_data  out  316  packed outgoing link word
txfifo_tx_vld  out  1  packed word valid
txfifo_tx_rdy  in  1  link FIFO ready
m_gen2_mode  in  1  1: all 4 channels active; 0: ch0/ch1 only

Behaviour:
- Clock/reset: one clock, clk_wr. rst_wr is synchronous and active-high.
- Reset values: all *_vld = 0, all FIFOs/holding registers empty, txfifo_tx_data = 0, rxfifo_rx_rdy = 0 during reset and 1 in the first cycle after reset.
- Active set: channels 0..3 when m_gen2_mode=1, channels 0..1 when 0. m_gen2_mode is quasi-static; changing it with data in flight is illegal (assertion).
- RX accept: rxfifo_rx_rdy = AND of "not full" over active channel FIFOs. It is registered-state only, with no combinational path from chN_rx_rdy.
- RX push: on rxfifo_rx_vld&rxfifo_rx_rdy, every active channel FIFO pushes its 79-bit slice. Inactive slices are discarded.
- RX output: chN_rx_vld = FIFO N not empty; chN_rx_data = head entry. Pop on chN_rx_vld&chN_rx_rdy.
- RX latency: 1 cycle from accept to chN_rx_vld.
- RX full FIFO: simultaneous push+pop is impossible because rdy is low. A pop frees the entry and rdy rises the next cycle.
- Inactive channels: chN_rx_vld=0 and chN_tx_rdy=0.
- TX holding: one holding register per channel. chN_tx_rdy = (holding empty) | (tx_fire), where tx_fire = txfifo_tx_vld&txfifo_tx_rdy. This is a combinational path from txfifo_tx_rdy and gives full throughput.
- TX valid: txfifo_tx_vld = all active holding registers full. txfifo_tx_data = concatenation of the holding registers, with inactive slices driven 0.
- TX fire: on tx_fire, all active holding registers clear, or reload in the same cycle if chN_tx_vld&chN_tx_rdy.
- Backpressure: txfifo_tx_vld and txfifo_tx_data stay stable while txfifo_tx_rdy=0.
- Reset mid-operation: all buffered data is discarded and no partial word is emitted.

Decomposition:
- Package aximm_ll_multi_tier2_pkg: CH_W, NUM_CH, LL_W localparams; ch_word_t typedef (logic [CH_W-1:0]).
- Sub-module ll_chan_fifo: synchronous FIFO, parameters WIDTH/DEPTH, outputs full/empty. Instantiated NUM_CH times on the RX path.
- TX holding registers are inline.

Test Plan:
- Reset: hold rst_wr 3 cycles, release -> all vld 0, rxfifo_rx_rdy=1 on first post-reset cycle, txfifo_tx_data=0.
- RX split: gen2, push word with slices 'h11,'h22,'h33,'h44, all chN_rx_rdy=1 -> next cycle ch0..ch3_rx_vld=1 with data 'h11..'h44, then 0.
- RX backpressure: ch2_rx_rdy=0, push 3 words back-to-back -> rxfifo_rx_rdy=0 after 2nd accept. Raise ch2_rx_rdy for 1 cycle -> rdy=1 next cycle, 3rd word accepted, no data lost or duplicated.
- TX alignment: ch0..ch2 valid at cycle 0, ch3 valid at cycle 5 -> txfifo_tx_vld=0 until cycle 6, then data = {ch3,ch2,ch1,ch0}. Hold txfifo_tx_rdy=0 4 cycles -> word stable.
- TX throughput: all channels stream continuously with txfifo_tx_rdy=1 -> one txfifo word per cycle after the first.
- Gen1 mode: m_gen2_mode=0 -> ch0/ch1 alone produce txfifo_tx_vld, bits [315:158]=0. ch2/3_rx_vld stay 0 and ch2/3_tx_rdy stay 0. Assert rst_wr with data buffered -> all vld 0 the next cycle.

Source files
------------

// File: rtl/aximm_ll_multi_tier2_pkg.sv
// Shared widths and types for the tier-2 AXI-MM multi-channel logic-link slave.
package aximm_ll_multi_tier2_pkg;

  localparam int unsigned CH_W   = 79;
  localparam int unsigned NUM_CH = 4;
  localparam int unsigned LL_W   = NUM_CH * CH_W;

  typedef logic [CH_W-1:0] ch_word_t;

  // Gen2 uses every channel; gen1 carries traffic on ch0/ch1 only.
  function automatic logic [NUM_CH-1:0] active_mask(input logic gen2);
    return gen2 ? {NUM_CH{1'b1}} : {{(NUM_CH-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/aximm_ll_multi_tier2_slave_name_ll_chan_fifo.sv
// Small synchronous per-channel FIFO with full/empty flags (power-of-two depth).
module ll_chan_fifo #(
  parameter int unsigned WIDTH = 79,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             push_ok, pop_ok;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage needs no reset: empty_o masks stale entries.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/aximm_ll_multi_tier2_slave_name.sv
// Slave-end logic-link name/packing: splits RX link words into per-channel FIFOs and
// aligns per-channel TX words into one packed link word.
module aximm_ll_multi_tier2_slave_name
  import aximm_ll_multi_tier2_pkg::*;
#(
  parameter int unsigned RX_DEPTH = 2
) (
  input  logic            clk_wr,
  input  logic            rst_wr,
  input  logic [LL_W-1:0] rxfifo_rx_data,
  input  logic            rxfifo_rx_vld,
  output logic            rxfifo_rx_rdy,
  output logic [CH_W-1:0] ch0_rx_data,
  output logic            ch0_rx_vld,
  input  logic            ch0_rx_rdy,
  output logic [CH_W-1:0] ch1_rx_data,
  output logic            ch1_rx_vld,
  input  logic            ch1_rx_rdy,
  output logic [CH_W-1:0] ch2_rx_data,
  output logic            ch2_rx_vld,
  input  logic            ch2_rx_rdy,
  output logic [CH_W-1:0] ch3_rx_data,
  output logic            ch3_rx_vld,
  input  logic            ch3_rx_rdy,
  input  logic [CH_W-1:0] ch0_tx_data,
  input  logic            ch0_tx_vld,
  output logic            ch0_tx_rdy,
  input  logic [CH_W-1:0] ch1_tx_data,
  input  logic            ch1_tx_vld,
  output logic            ch1_tx_rdy,
  input  logic [CH_W-1:0] ch2_tx_data,
  input  logic            ch2_tx_vld,
  output logic            ch2_tx_rdy,
  input  logic [CH_W-1:0] ch3_tx_data,
  input  logic            ch3_tx_vld,
  output logic            ch3_tx_rdy,
  output logic [LL_W-1:0] txfifo_tx_data,
  output logic            txfifo_tx_vld,
  input  logic            txfifo_tx_rdy,
  input  logic            m_gen2_mode
);

  logic [NUM_CH-1:0] active;
  assign active = active_mask(m_gen2_mode);

  // ---------------------------------------------------------------- RX path
  logic [NUM_CH-1:0] fifo_full, fifo_empty, rx_push, rx_pop, ch_rx_vld, ch_rx_rdy;
  ch_word_t          rx_head [NUM_CH];
  logic              rx_en_q, rx_fire;

  // Holds rxfifo_rx_rdy low through reset and releases it on the first free cycle.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) rx_en_q <= 1'b0;
    else        rx_en_q <= 1'b1;
  end

  // Ready only from registered FIFO state, never from the channel consumers.
  assign rxfifo_rx_rdy = rx_en_q & (&(~fifo_full | ~active));
  assign rx_fire       = rxfifo_rx_vld & rxfifo_rx_rdy;
  assign rx_push       = {NUM_CH{rx_fire}} & active;
  assign ch_rx_rdy     = {ch3_rx_rdy, ch2_rx_rdy, ch1_rx_rdy, ch0_rx_rdy};
  assign ch_rx_vld     = active & ~fifo_empty;
  assign rx_pop        = ch_rx_vld & ch_rx_rdy;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_rx_fifo
    ll_chan_fifo #(
      .WIDTH (CH_W),
      .DEPTH (RX_DEPTH)
    ) u_fifo (
      .clk_i   (clk_wr),
      .rst_i   (rst_wr),
      .push_i  (rx_push[k]),
      .wdata_i (rxfifo_rx_data[k*CH_W +: CH_W]),
      .pop_i   (rx_pop[k]),
      .rdata_o (rx_head[k]),
      .full_o  (fifo_full[k]),
      .empty_o (fifo_empty[k])
    );
  end

  assign {ch3_rx_vld, ch2_rx_vld, ch1_rx_vld, ch0_rx_vld} = ch_rx_vld;
  assign ch0_rx_data = rx_head[0];
  assign ch1_rx_data = rx_head[1];
  assign ch2_rx_data = rx_head[2];
  assign ch3_rx_data = rx_head[3];

  // ---------------------------------------------------------------- TX path
  ch_word_t          hold_q [NUM_CH];
  ch_word_t          hold_d [NUM_CH];
  ch_word_t          ch_tx_data [NUM_CH];
  logic [NUM_CH-1:0] hold_vld_q, hold_vld_d, ch_tx_vld, ch_tx_rdy;
  logic              tx_fire;

  assign ch_tx_data[0] = ch0_tx_data;
  assign ch_tx_data[1] = ch1_tx_data;
  assign ch_tx_data[2] = ch2_tx_data;
  assign ch_tx_data[3] = ch3_tx_data;
  assign ch_tx_vld     = {ch3_tx_vld, ch2_tx_vld, ch1_tx_vld, ch0_tx_vld};

  assign txfifo_tx_vld = &(hold_vld_q | ~active);
  assign tx_fire       = txfifo_tx_vld & txfifo_tx_rdy;
  // A full holding slot accepts a new word in the cycle it drains, for full throughput.
  assign ch_tx_rdy     = active & (~hold_vld_q | {NUM_CH{tx_fire}});
  assign {ch3_tx_rdy, ch2_tx_rdy, ch1_tx_rdy, ch0_tx_rdy} = ch_tx_rdy;

  // Next-state for the holding registers: reload wins over clear on a link fire.
  always_comb begin
    hold_vld_d = hold_vld_q;
    for (int k = 0; k < NUM_CH; k++) begin
      hold_d[k] = hold_q[k];
      if (ch_tx_vld[k] && ch_tx_rdy[k]) begin
        hold_d[k]     = ch_tx_data[k];
        hold_vld_d[k] = 1'b1;
      end else if (tx_fire && active[k]) begin
        hold_d[k]     = '0;
        hold_vld_d[k] = 1'b0;
      end
    end
  end

  // Holding register state.
  always_ff @(posedge clk_wr) begin
    if (rst_wr) begin
      hold_vld_q <= '0;
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      for (int k = 0; k < NUM_CH; k++) hold_q[k] <= hold_d[k];
    end
  end

  // Packed link word; inactive slices forced to zero.
  always_comb begin
    txfifo_tx_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      txfifo_tx_data[k*CH_W +: CH_W] = active[k] ? hold_q[k] : '0;
    end
  end

  // ------------------------------------------------------------- mode check
  logic mode_q;
  logic idle;

  // Previous-cycle mode, used to detect a mode change.
  always_ff @(posedge clk_wr) begin
    mode_q <= m_gen2_mode;
  end

  assign idle = (&fifo_empty) & ~(|hold_vld_q);

  mode_static_a : assert property (@(posedge clk_wr) disable iff (rst_wr)
                                   (m_gen2_mode == mode_q) || idle);

endmodule
